// File: rtl/l1c_mem_pkg.sv
// Shared types and constants for the L1 cache memory responder and its arbiter.
package l1c_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int DEFAULT_LATENCY = 4;

endpackage

// File: rtl/l1c_mem_arb.sv
// Two-way I/D grant logic. Fixed D-over-I priority by default; defining
// L1C_MEM_RR_EN switches contention handling to round-robin on last-served.
module l1c_mem_arb
    import l1c_mem_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic take_i,
    output logic gnt_d_o
);

`ifdef L1C_MEM_RR_EN
    logic last_q;
    logic last_d;

    // Starting as I after reset makes D the winner of the first contention.
    assign gnt_d_o = d_req_i && (!i_req_i || (last_q == OWN_I));
    assign last_d  = gnt_d_o ? OWN_D : OWN_I;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWN_I;
        end else if (take_i) begin
            last_q <= last_d;
        end
    end
`else
    logic unused_fixed;
    assign unused_fixed = ^{clk_i, rst_i, i_req_i, take_i};
    assign gnt_d_o      = d_req_i;
`endif

endmodule

// File: rtl/l1c_mem_responder.sv
// Memory-side responder for the L1 I/D caches: arbitrates, inserts LATENCY wait
// states and performs one SRAM word access per transaction. Option: L1C_MEM_RR_EN.
module l1c_mem_responder
    import l1c_mem_pkg::*;
#(
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int MEM_WORDS = 16384,
    localparam int AW       = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          I_req,
    input  logic [31:0]   I_addr,
    output logic [31:0]   I_out,
    output logic          I_wait,
    input  logic          D_req,
    input  logic [31:0]   D_addr,
    input  logic          D_write,
    input  logic [3:0]    D_wstrb,
    input  logic [31:0]   D_in,
    output logic [31:0]   D_out,
    output logic          D_wait,
    output logic          mem_ce,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [7:0] LAT8 = 8'(LATENCY);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          take;
    logic          gnt_d;
    logic          resp_i;
    logic          resp_d;

    // Byte-offset bits and bits above the SRAM range are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{I_addr[1:0], I_addr[31:AW+2], D_addr[1:0], D_addr[31:AW+2]};

    assign take = (state_q == IDLE) && (I_req || D_req);

    l1c_mem_arb u_arb (
        .clk_i   (clk),
        .rst_i   (rst),
        .i_req_i (I_req),
        .d_req_i (D_req),
        .take_i  (take),
        .gnt_d_o (gnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wstrb_q <= wstrb_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        mem_ce    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    owner_d = gnt_d ? OWN_D : OWN_I;
                    addr_d  = gnt_d ? D_addr[AW+1:2] : I_addr[AW+1:2];
                    we_d    = gnt_d && D_write;
                    wstrb_d = D_wstrb;
                    wdata_d = D_in;
                    cnt_d   = LAT8;
                    state_d = (LAT8 == 8'd0) ? ACC : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                mem_ce   = 1'b1;
                mem_addr = addr_q;
                if (we_q) begin
                    mem_we    = wstrb_q;
                    mem_wdata = wdata_q;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Wait is purely combinational on req so a dropped request never reads as stalled.
    assign resp_i = (state_q == RESP) && (owner_q == OWN_I);
    assign resp_d = (state_q == RESP) && (owner_q == OWN_D);
    assign I_wait = I_req && !resp_i;
    assign D_wait = D_req && !resp_d;
    assign I_out  = resp_i ? mem_rdata : 32'h0;
    assign D_out  = (resp_d && !we_q) ? mem_rdata : 32'h0;

endmodule
